data_mem: RTL and testbench

- Single-port, word-organised data memory for the single-cycle stack CPU.
- Serves load/store traffic from the datapath.
- Read and write have independent enables.
- Synchronous write, registered (one-cycle) read, asynchronous active-high reset.

---
 rtl/data_mem_pkg.sv | 18 +
 rtl/data_mem_if.sv | 39 +++
 rtl/data_mem.sv | 57 +++++
 tb/tb_data_mem.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/data_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_pkg
// Brief    : Shared constants and word type for the stack CPU data memory.
// Revision : 1.0 - initial release
// ============================================================================
package data_mem_pkg;

    // Default geometry: 32-bit byte address, 32-bit word, 256 words.
    localparam int DEFAULT_ABITS      = 32;
    localparam int DEFAULT_DBITS      = 32;
    localparam int DEFAULT_DEPTH_LOG2 = 8;

    // Machine word, shared with the datapath and instruction memory.
    typedef logic [DEFAULT_DBITS-1:0] word_t;

endpackage : data_mem_pkg
`default_nettype wire

// File: rtl/data_mem_if.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_if
// Brief    : Load/store bus between the CPU datapath and the data memory.
// Revision : 1.0 - initial release
// ============================================================================
interface data_mem_if
    import data_mem_pkg::*;
#(
    parameter int ABITS = DEFAULT_ABITS,
    parameter int DBITS = DEFAULT_DBITS
) ();

    logic             en;    // read enable
    logic             we;    // write enable
    logic [ABITS-1:0] addr;  // byte address, word aligned
    logic [DBITS-1:0] din;   // write data
    logic [DBITS-1:0] dout;  // registered read data

    // Datapath side drives the request and consumes read data.
    modport master (
        output en,
        output we,
        output addr,
        output din,
        input  dout
    );

    // Memory side.
    modport slave (
        input  en,
        input  we,
        input  addr,
        input  din,
        output dout
    );

endinterface : data_mem_if
`default_nettype wire

// File: rtl/data_mem.sv
`default_nettype none
// ============================================================================
// Module   : data_mem
// Brief    : Single-port word-organised data memory. Synchronous write,
//            one-cycle registered read (read-first on collision),
//            asynchronous active-high reset clearing storage and dout.
// Revision : 1.0 - initial release
// ============================================================================
module data_mem
    import data_mem_pkg::*;
#(
    parameter int ABITS      = DEFAULT_ABITS,
    parameter int DBITS      = DEFAULT_DBITS,
    parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2
) (
    input  wire logic   clk,
    input  wire logic   rst,
    data_mem_if.slave   bus
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [DBITS-1:0]      r_mem [DEPTH];
    logic [DBITS-1:0]      r_dout;
    logic [DEPTH_LOG2-1:0] w_index;
    logic                  w_unused_addr_bits;

    // Word index: byte offset dropped, upper bits dropped so addresses wrap.
    assign w_index = bus.addr[DEPTH_LOG2+1:2];

    // Ignored address bits are gathered here so they are visibly intentional.
    assign w_unused_addr_bits = ^{bus.addr[ABITS-1:DEPTH_LOG2+2], bus.addr[1:0]};

    assign bus.dout = r_dout;

    // Storage: cleared by reset, full-word write when we is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (bus.we) begin
            r_mem[w_index] <= bus.din;
        end
    end

    // Read register: samples pre-write contents (read-first), holds when en=0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dout <= '0;
        end else if (bus.en) begin
            r_dout <= r_mem[w_index];
        end
    end

endmodule : data_mem
`default_nettype wire

// File: tb/tb_data_mem.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_mem
// Brief    : Directed self-checking bench for data_mem.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_mem;
    import data_mem_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    data_mem_if #(.ABITS(32), .DBITS(32)) bus ();

    data_mem #(
        .ABITS      (32),
        .DBITS      (32),
        .DEPTH_LOG2 (8)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input word_t exp);
        checks++;
        assert (bus.dout === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, bus.dout, exp);
        end
    endtask

    task automatic drive(input logic en, input logic we,
                         input logic [31:0] addr, input word_t din);
        bus.en   = en;
        bus.we   = we;
        bus.addr = addr;
        bus.din  = din;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 32'h0);

        // Reset state
        #2;
        chk("reset_dout", 32'h0000_0000);
        tick();
        tick();
        rst = 1'b0;

        // Read after reset
        drive(1'b1, 1'b0, 32'h0, 32'h0);
        tick();
        chk("read0_after_reset", 32'h0000_0000);

        // Write then read back; dout holds during the en=0 write
        drive(1'b0, 1'b1, 32'h0, 32'h0000_F123);
        tick();
        chk("hold_during_write", 32'h0000_0000);
        drive(1'b1, 1'b0, 32'h0, 32'h0);
        tick();
        chk("readback0", 32'h0000_F123);

        // Read-first collision
        drive(1'b1, 1'b1, 32'h0, 32'hDEAD_BEEF);
        tick();
        chk("collision_old", 32'h0000_F123);
        drive(1'b1, 1'b0, 32'h0, 32'h0);
        tick();
        chk("collision_new", 32'hDEAD_BEEF);

        // Hold and alias; din is X while we=0
        drive(1'b0, 1'b1, 32'h4, 32'h1234_5678);
        tick();
        drive(1'b1, 1'b0, 32'h4, 'x);
        tick();
        chk("read4", 32'h1234_5678);
        drive(1'b0, 1'b0, 32'h0, 'x);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_en0", 32'h1234_5678);
        end
        drive(1'b1, 1'b0, 32'h404, 'x);
        tick();
        chk("alias_404", 32'h1234_5678);
        drive(1'b1, 1'b0, 32'h7, 'x);
        tick();
        chk("alias_7", 32'h1234_5678);
        drive(1'b1, 1'b0, 32'hFFFF_FC00, 'x);
        tick();
        chk("alias_high_0", 32'hDEAD_BEEF);
        drive(1'b1, 1'b0, 32'h4, 'x);
        tick();
        chk("x_din_no_corrupt", 32'h1234_5678);

        // Write with en=0 leaves dout unchanged
        drive(1'b0, 1'b1, 32'h8, 32'hA5A5_A5A5);
        tick();
        chk("write_en0_hold", 32'h1234_5678);
        drive(1'b1, 1'b0, 32'h8, 32'h0);
        tick();
        chk("read8", 32'hA5A5_A5A5);

        // Async reset mid-cycle with an access in flight
        drive(1'b1, 1'b1, 32'h4, 32'hFFFF_FFFF);
        #3;
        rst = 1'b1;
        #1;
        chk("async_reset_now", 32'h0000_0000);
        @(posedge clk);
        #1;
        chk("reset_held_edge", 32'h0000_0000);
        #2;
        rst = 1'b0;
        drive(1'b1, 1'b0, 32'h0, 32'h0);
        tick();
        chk("post_reset_0", 32'h0000_0000);
        drive(1'b1, 1'b0, 32'h4, 32'h0);
        tick();
        chk("post_reset_4", 32'h0000_0000);
        drive(1'b1, 1'b0, 32'h8, 32'h0);
        tick();
        chk("post_reset_8", 32'h0000_0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_data_mem
`default_nettype wire
